// File: rtl/load_writeback_unit_pkg.sv
// Shared RISC-V load definitions: widths, load funct3 codes, FSM states, captured-load struct.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } lwu_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        f3;
    logic [1:0]        off;
  } ld_req_t;

  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction
endpackage

// File: rtl/load_writeback_unit_if.sv
// Data-memory read port: req/gnt address phase, rvalid/rdata response phase.
interface load_writeback_unit_if;
  import riscv_pkg::*;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_writeback_unit_align.sv
// Byte/half lane select and sign/zero extension of a returned load word.
// LOAD_MISALIGN_TRAP_EN: flag unaligned LH/LHU/LW instead of silently ignoring low bits.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (addr_lo)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wdata = rdata;
    unique case (funct3)
      F3_LB:   wdata = {{24{b[7]}}, b};
      F3_LBU:  wdata = {24'h0, b};
      F3_LH:   wdata = {{16{h[15]}}, h};
      F3_LHU:  wdata = {16'h0, h};
      default: wdata = rdata;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misaligned = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr_lo[0]) ||
                      ((funct3 == F3_LW) && (addr_lo != 2'b00));
`else
  logic unused_lo;
  assign unused_lo  = addr_lo[0];
  assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/load_writeback_unit.sv
// Load FSM: issues one word read, aligns the response and writes the register file.
// LOAD_MISALIGN_TRAP_EN (see load_align) turns unaligned loads into no-access completions.
module load_writeback_unit
  import riscv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              inst,
  input  logic [XLEN-1:0]          addr,
  output logic                     busy,
  output logic                     done,
  output logic                     misalign,
  load_writeback_unit_if.master    mem,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]          rf_wdata
);
  lwu_state_e      state;
  ld_req_t         cur;
  logic [2:0]      f3_sel;
  logic [1:0]      off_sel;
  logic [XLEN-1:0] al_data;
  logic            al_mis;
  logic            unused_inst;

  assign unused_inst = ^{inst[31:15], inst[6:0]};

  // One aligner serves both the issue-time misalign test and the response path.
  assign f3_sel  = (state == ST_IDLE) ? inst[14:12] : cur.f3;
  assign off_sel = (state == ST_IDLE) ? addr[1:0]   : cur.off;

  load_align u_align (
    .funct3     (f3_sel),
    .addr_lo    (off_sel),
    .rdata      (mem.mem_rdata),
    .wdata      (al_data),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      misalign     <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      rf_we    <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) begin
          cur.rd   <= inst[11:7];
          cur.f3   <= inst[14:12];
          cur.off  <= addr[1:0];
          rf_waddr <= inst[11:7];
          busy     <= 1'b1;
          if (!f3_valid(inst[14:12]) || al_mis) begin
            state    <= ST_WB;
            done     <= 1'b1;
            misalign <= al_mis;
          end else begin
            state        <= ST_REQ;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= {addr[XLEN-1:2], 2'b00};
          end
        end
        ST_REQ: if (mem.mem_gnt) begin
          mem.mem_req <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: if (mem.mem_rvalid) begin
          state    <= ST_WB;
          done     <= 1'b1;
          rf_we    <= (cur.rd != '0);
          rf_wdata <= al_data;
        end
        ST_WB: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_writeback_unit.sv
// Randomized load traffic against an arithmetic reference model of load semantics and timing.
module tb_load_writeback_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] addr = '0;
  logic        busy, done, misalign, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int          errs = 0;
  int          checks = 0;

  load_writeback_unit_if mem ();

  always #5 clk = ~clk;

  load_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .addr(addr),
    .busy(busy), .done(done), .misalign(misalign), .mem(mem),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LOAD_MISALIGN_TRAP_EN
    return ((f3 == F3_LH || f3 == F3_LHU) && (a % 2 != 0)) || (f3 == F3_LW && (a % 4 != 0));
`else
    return (f3 == 3'b111) && (a == 32'h1) && (f3 == 3'b000);
`endif
  endfunction

  function automatic bit ref_access(input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return legal && !ref_mis(f3, a);
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [7:0]  bv;
    logic [15:0] hv;
    int          s;
    bv = 8'(d >> ((a % 4) * 8));
    hv = ((a / 2) % 2 == 1) ? 16'(d >> 16) : 16'(d);
    case (f3)
      3'd0:    begin s = $signed(bv); return s; end
      3'd1:    begin s = $signed(hv); return s; end
      3'd4:    return 32'(bv);
      3'd5:    return 32'(hv);
      default: return d;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_mem_req"}, 32'(mem.mem_req), 32'd0);
  endtask

  task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gd, input int rdl, input bit noise);
    bit          acc, granted, seen;
    int          exp_cyc, reqcnt, waitcnt;
    logic [31:0] exp_addr;
    acc      = ref_access(f3, a);
    exp_addr = a - (a % 4);
    exp_cyc  = acc ? 3 + gd + rdl : 1;
    granted  = 0; seen = 0; reqcnt = 0; waitcnt = 0;
    @(negedge clk);
    inst  = {17'($urandom), f3, rd, 7'h03};
    addr  = a;
    start = 1'b1;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
    for (int cyc = 1; cyc <= exp_cyc + 20 && !seen; cyc++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin inst = $urandom; addr = $urandom; end
      mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = $urandom;
      check("busy", 32'(busy), 32'd1);
      if (done) begin
        seen = 1;
        check("done_cyc", cyc, exp_cyc);
        check("rf_we", 32'(rf_we), 32'(acc && rd != 0));
        check("misalign", 32'(misalign), 32'(ref_mis(f3, a)));
        if (acc && rd != 0) begin
          check("rf_waddr", 32'(rf_waddr), 32'(rd));
          check("rf_wdata", rf_wdata, ref_data(f3, a, d));
        end
      end else begin
        check("rf_we_early", 32'(rf_we), 32'd0);
        check("mem_req", 32'(mem.mem_req), 32'(acc && !granted));
        if (mem.mem_req) begin
          check("mem_addr", mem.mem_addr, exp_addr);
          if (reqcnt == gd) begin mem.mem_gnt = 1'b1; granted = 1; end
          reqcnt++;
          if (noise) mem.mem_rvalid = 1'($urandom_range(0, 1));
        end else if (granted) begin
          if (waitcnt == rdl) begin mem.mem_rvalid = 1'b1; mem.mem_rdata = d; end
          waitcnt++;
        end
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
    check_idle("after");
  endtask

  initial begin
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_req", 32'(mem.mem_req), 32'd0);
    check("rst_maddr", mem.mem_addr, 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_load(5'd5, F3_LW,  32'h100, 32'hDEADBEEF, 0, 0, 0);
    run_load(5'd3, F3_LB,  32'h103, 32'h80123456, 0, 0, 0);
    run_load(5'd4, F3_LBU, 32'h103, 32'h80123456, 0, 0, 0);
    run_load(5'd6, F3_LH,  32'h102, 32'h80011234, 1, 2, 0);
    run_load(5'd7, F3_LHU, 32'h100, 32'h80011234, 0, 1, 0);
    run_load(5'd0, F3_LW,  32'h104, 32'h12345678, 3, 0, 0);
    run_load(5'd9, 3'b011, 32'h108, 32'h0BADF00D, 0, 0, 0);
    run_load(5'd9, 3'b110, 32'h10C, 32'h0BADF00D, 0, 0, 1);
    run_load(5'd8, F3_LW,  32'h101, 32'hCAFEF00D, 0, 0, 0);
    run_load(5'd8, F3_LH,  32'h103, 32'hA5A5C3C3, 0, 0, 0);

    for (int i = 0; i < 150; i++)
      run_load(5'($urandom), 3'($urandom), $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 1);

    // Reset while waiting for read data; the late rvalid must not write.
    @(negedge clk);
    inst = {17'h0, F3_LW, 5'd7, 7'h03}; addr = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem.mem_gnt = 1'b1;
    check("rw_req", 32'(mem.mem_req), 32'd1);
    @(negedge clk);
    mem.mem_gnt = 1'b0;
    check("rw_wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_req0", 32'(mem.mem_req), 32'd0);
    check("rw_maddr", mem.mem_addr, 32'd0);
    check("rw_wdata", rf_wdata, 32'd0);
    check("rw_waddr", 32'(rf_waddr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem.mem_rvalid = 1'b1; mem.mem_gnt = 1'b1; mem.mem_rdata = 32'h11223344;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rw_late");
    end
    mem.mem_rvalid = 1'b0; mem.mem_gnt = 1'b0;
    run_load(5'd2, F3_LW, 32'h300, 32'h55AA55AA, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
